// File: rtl/issue_control_pkg.sv
// issue_control_pkg: shared opcodes, instruction field positions and FSM states.
package issue_control_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_LI  = 2'b11;
    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RS_HI  = 5;
    localparam int RS_LO  = 4;
    localparam int RT_HI  = 3;
    localparam int RT_LO  = 2;
    localparam int RD_HI  = 1;
    localparam int RD_LO  = 0;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;
    typedef enum logic [2:0] {IDLE, DECODE, READ, EXEC, WB} state_t;
endpackage

// File: rtl/issue_control_alu_unit.sv
// alu_unit: combinational ADD/SUB/AND/load-immediate, modulo 2^DATA_W.
module alu_unit
    import issue_control_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [3:0]        imm_i,
    output logic [DATA_W-1:0] y_o
);
    always_comb begin
        y_o = op_i == OP_ADD ? a_i + b_i :
              op_i == OP_SUB ? a_i - b_i :
              op_i == OP_AND ? a_i & b_i : DATA_W'(imm_i);
    end
endmodule

// File: rtl/issue_control.sv
// issue_control: 5-cycle decode/issue FSM driving a sync-read register file; ISSUE_ZERO_REG_EN hardwires r0.
module issue_control
    import issue_control_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int RADDR_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [7:0]         instr_data,
    output logic               instr_ready,
    output logic [RADDR_W-1:0] rf_read_addr1,
    output logic [RADDR_W-1:0] rf_read_addr2,
    input  logic [DATA_W-1:0]  rf_read_data1,
    input  logic [DATA_W-1:0]  rf_read_data2,
    output logic               rf_write_enable,
    output logic [RADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0]  rf_write_data,
    output logic               busy,
    output logic               retired,
    output logic [CNT_W-1:0]   retire_count,
    output logic               zero_flag
);
    state_t              state_q, state_d;
    logic [7:0]          instr_q;
    logic [RADDR_W-1:0]  ra1_q, ra2_q, wa_q;
    logic [DATA_W-1:0]   opa_q, opb_q, wd_q, alu_y;
    logic                we_q, retired_q, zero_q, wr_en;
    logic [CNT_W-1:0]    cnt_q;
    logic [1:0]          op, rd;

    assign op = instr_q[OP_HI:OP_LO];
    // LI reuses the rs field as its destination
    assign rd = op == OP_LI ? instr_q[RS_HI:RS_LO] : instr_q[RD_HI:RD_LO];

`ifdef ISSUE_ZERO_REG_EN
    assign wr_en = rd != 2'd0;
`else
    assign wr_en = 1'b1;
`endif

    alu_unit #(.DATA_W(DATA_W)) u_alu (
        .op_i  (op),
        .a_i   (opa_q),
        .b_i   (opb_q),
        .imm_i (instr_q[IMM_HI:IMM_LO]),
        .y_o   (alu_y)
    );

    always_comb begin
        state_d = state_q == IDLE   ? (instr_valid ? DECODE : IDLE) :
                  state_q == DECODE ? READ :
                  state_q == READ   ? EXEC :
                  state_q == EXEC   ? WB : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            ra1_q     <= '0;
            ra2_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            we_q      <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
            retired_q <= 1'b0;
            cnt_q     <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= 1'b0;
            retired_q <= 1'b0;
            if (state_q == IDLE && instr_valid) begin
                instr_q <= instr_data;
                ra1_q   <= RADDR_W'(instr_data[RS_HI:RS_LO]);
                ra2_q   <= RADDR_W'(instr_data[RT_HI:RT_LO]);
            end
            if (state_q == READ) begin
                opa_q <= rf_read_data1;
                opb_q <= rf_read_data2;
            end
            // write-back, retire and flag all land together so they are visible in WB
            if (state_q == EXEC) begin
                we_q      <= wr_en;
                wa_q      <= RADDR_W'(rd);
                wd_q      <= alu_y;
                retired_q <= 1'b1;
                cnt_q     <= cnt_q + CNT_W'(1);
                zero_q    <= alu_y == '0;
            end
        end
    end

    assign instr_ready     = state_q == IDLE;
    assign busy            = state_q != IDLE;
    assign rf_read_addr1   = ra1_q;
    assign rf_read_addr2   = ra2_q;
    assign rf_write_enable = we_q;
    assign rf_write_addr   = wa_q;
    assign rf_write_data   = wd_q;
    assign retired         = retired_q;
    assign retire_count    = cnt_q;
    assign zero_flag       = zero_q;
endmodule

// File: tb/tb_issue_control.sv
// tb_issue_control: directed checks of issue_control against a 4x8 sync-read register file.
module tb_issue_control;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [7:0]  instr_data = '0;
    logic        instr_ready, rf_write_enable, busy, retired, zero_flag;
    logic [1:0]  rf_read_addr1, rf_read_addr2, rf_write_addr;
    logic [7:0]  rf_read_data1 = '0, rf_read_data2 = '0, rf_write_data;
    logic [15:0] retire_count;
    logic [7:0]  regs [4];
    int          total = 0, bad = 0, exp_cnt = 0, we_seen = 0;

    issue_control dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_valid     (instr_valid),
        .instr_data      (instr_data),
        .instr_ready     (instr_ready),
        .rf_read_addr1   (rf_read_addr1),
        .rf_read_addr2   (rf_read_addr2),
        .rf_read_data1   (rf_read_data1),
        .rf_read_data2   (rf_read_data2),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .busy            (busy),
        .retired         (retired),
        .retire_count    (retire_count),
        .zero_flag       (zero_flag)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 4; i++) regs[i] = '0;

    always @(posedge clk) begin
        rf_read_data1 <= regs[rf_read_addr1];
        rf_read_data2 <= regs[rf_read_addr2];
        if (rf_write_enable) begin
            regs[rf_write_addr] <= rf_write_data;
            we_seen <= we_seen + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [7:0] ins, input logic [1:0] exp_addr,
                       input logic [7:0] exp_data, input logic exp_we, input bit hold);
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", instr_ready, 1);
        instr_valid = 1'b1;
        instr_data  = ins;
        @(posedge clk);
        #1;
        if (!hold) instr_valid = 1'b0;
        exp_cnt++;
        for (int c = 1; c <= 4; c++) begin
            if (hold) instr_data = 8'(ins ^ (8'h5A + 8'(c)));
            @(negedge clk);
            check("ready_low", instr_ready, 0);
            check("busy", busy, 1);
            check("we", rf_write_enable, c == 4 ? exp_we : 1'b0);
            check("retired", retired, c == 4 ? 1 : 0);
        end
        if (exp_we) begin
            check("waddr", rf_write_addr, exp_addr);
            check("wdata", rf_write_data, exp_data);
        end
        check("count", retire_count, exp_cnt);
        check("zero", zero_flag, exp_data == 8'h00);
        instr_valid = 1'b0;
    endtask

    initial begin
        bit zr;
        int we_before;
`ifdef ISSUE_ZERO_REG_EN
        zr = 1'b1;
`else
        zr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_we", rf_write_enable, 0);
        check("rst_retired", retired, 0);
        check("rst_count", retire_count, 0);
        check("rst_zero", zero_flag, 0);
        check("rst_ra1", rf_read_addr1, 0);
        check("rst_wdata", rf_write_data, 0);

        run(8'hD5, 2'd1, 8'h05, 1'b1, 1'b0);
        run(8'hE3, 2'd2, 8'h03, 1'b1, 1'b0);
        run(8'h1B, 2'd3, 8'h08, 1'b1, 1'b0);
        run(8'h64, 2'd0, 8'hFE, !zr, 1'b0);

        run(8'hDF, 2'd1, 8'h0F, 1'b1, 1'b0);
        run(8'h15, 2'd1, 8'h1E, 1'b1, 1'b0);
        run(8'h15, 2'd1, 8'h3C, 1'b1, 1'b0);
        run(8'h15, 2'd1, 8'h78, 1'b1, 1'b0);
        run(8'h15, 2'd1, 8'hF0, 1'b1, 1'b0);
        run(8'h15, 2'd1, 8'hE0, 1'b1, 1'b0);

        run(8'hD5, 2'd1, 8'h05, 1'b1, 1'b0);
        run(8'hE2, 2'd2, 8'h02, 1'b1, 1'b0);
        run(8'h9B, 2'd3, 8'h00, 1'b1, 1'b1);
        run(8'h1B, 2'd3, 8'h07, 1'b1, 1'b1);
        check("reg3", regs[3], 8'h00);
        @(negedge clk);
        check("reg3_after", regs[3], 8'h07);

        we_before = we_seen;
        @(negedge clk);
        instr_valid = 1'b1;
        instr_data  = 8'h1B;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_we", rf_write_enable, 0);
        check("abort_retired", retired, 0);
        check("abort_count", retire_count, 0);
        check("abort_zero", zero_flag, 0);
        check("abort_busy", busy, 0);
        check("abort_waddr", rf_write_addr, 0);
        check("abort_wdata", rf_write_data, 0);
        check("abort_ra1", rf_read_addr1, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_write", we_seen, we_before);
        check("abort_ready", instr_ready, 1);
        check("abort_reg3", regs[3], 8'h07);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
